// File: rtl/bash_s_array.sv
// bash_s_array: bash-S layer over a 24-word state, LANES columns per cycle.
//   clk_i, rst_i           clock, synchronous active-high reset
//   in_valid_i/in_ready_o  input handshake, state_i captured in IDLE
//   out_valid_o/out_ready_i output handshake, state_o held in DONE
//   state_i/state_o        24*SLEN state, word k at [k*SLEN +: SLEN]
// Column j is (word j, word j+8, word j+16). Columns are processed in place,
// cnt_q .. cnt_q+LANES-1 per RUN cycle, each lane picking its rotation set
// from the column index it is working on.

package bash_hash_params_pkg;
  parameter int SLEN = 64;
endpackage

// One bash-S instance; rotation amounts arrive as inputs so a lane can serve
// any column.
module bash_s_lane #(
  parameter int SLEN = 64
) (
  input  logic [SLEN-1:0] w0_i,
  input  logic [SLEN-1:0] w1_i,
  input  logic [SLEN-1:0] w2_i,
  input  logic [7:0]      m1_i,
  input  logic [7:0]      n1_i,
  input  logic [7:0]      m2_i,
  input  logic [7:0]      n2_i,
  output logic [SLEN-1:0] y0_o,
  output logic [SLEN-1:0] y1_o,
  output logic [SLEN-1:0] y2_o
);
  function automatic logic [SLEN-1:0] bswap(input logic [SLEN-1:0] x);
    logic [SLEN-1:0] y;
    y = '0;
    for (int b = 0; b < SLEN/8; b++) y[8*b +: 8] = x[SLEN-8-8*b +: 8];
    return y;
  endfunction

  // Rotation on the little-endian reading of the word. A shift by SLEN
  // yields zero, so s = 0 needs no special case.
  function automatic logic [SLEN-1:0] lrot(input logic [SLEN-1:0] x, input logic [7:0] r);
    logic [SLEN-1:0] bx;
    int s;
    bx = bswap(x);
    s  = int'(r) % SLEN;
    return bswap((bx << s) | (bx >> (SLEN - s)));
  endfunction

  logic [SLEN-1:0] w0, t1, w1, w2;

  assign w0   = w0_i ^ w1_i ^ w2_i;
  assign t1   = w1_i ^ lrot(w0, n1_i);
  assign w1   = lrot(w0_i, m1_i) ^ t1;
  assign w2   = w2_i ^ lrot(w2_i, m2_i) ^ lrot(t1, n2_i);
  assign y0_o = w0 ^ (~w2 | w1);
  assign y1_o = w1 ^ (w0 | w2);
  assign y2_o = w2 ^ (w0 & w1);
endmodule

module bash_s_array #(
  parameter int SLEN  = bash_hash_params_pkg::SLEN,
  parameter int LANES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24*SLEN-1:0] state_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [24*SLEN-1:0] state_o
);
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("bash_s_array: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  typedef struct packed {
    logic [7:0] m1;
    logic [7:0] n1;
    logic [7:0] m2;
    logic [7:0] n2;
  } rot_t;

  // Last column group start; the counter stops here instead of wrapping.
  localparam logic [2:0] LAST = 3'(8 - LANES);

  function automatic rot_t rot_sel(input logic [2:0] j);
    case (j)
      3'd0:    return '{8'd8,  8'd53, 8'd14, 8'd1};
      3'd1:    return '{8'd56, 8'd51, 8'd34, 8'd7};
      3'd2:    return '{8'd8,  8'd37, 8'd46, 8'd49};
      3'd3:    return '{8'd56, 8'd3,  8'd2,  8'd23};
      3'd4:    return '{8'd8,  8'd21, 8'd14, 8'd33};
      3'd5:    return '{8'd56, 8'd19, 8'd34, 8'd39};
      3'd6:    return '{8'd8,  8'd5,  8'd46, 8'd17};
      default: return '{8'd56, 8'd35, 8'd2,  8'd55};
    endcase
  endfunction

  fsm_e                fsm_q, fsm_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [24*SLEN-1:0]  st_q, st_d, st_run;

  logic [LANES-1:0][2:0]      col;
  logic [LANES-1:0][SLEN-1:0] w0, w1, w2, y0, y1, y2;
  rot_t [LANES-1:0]           rot;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign col[l] = cnt_q + 3'(l);
    assign rot[l] = rot_sel(col[l]);
    assign w0[l]  = st_q[int'(col[l])*SLEN +: SLEN];
    assign w1[l]  = st_q[(int'(col[l])+8)*SLEN +: SLEN];
    assign w2[l]  = st_q[(int'(col[l])+16)*SLEN +: SLEN];

    bash_s_lane #(.SLEN(SLEN)) u_lane (
      .w0_i (w0[l]),
      .w1_i (w1[l]),
      .w2_i (w2[l]),
      .m1_i (rot[l].m1),
      .n1_i (rot[l].n1),
      .m2_i (rot[l].m2),
      .n2_i (rot[l].n2),
      .y0_o (y0[l]),
      .y1_o (y1[l]),
      .y2_o (y2[l])
    );
  end

  // Lanes touch disjoint columns, so writeback order does not matter.
  always_comb begin
    st_run = st_q;
    for (int l = 0; l < LANES; l++) begin
      st_run[int'(col[l])*SLEN +: SLEN]      = y0[l];
      st_run[(int'(col[l])+8)*SLEN +: SLEN]  = y1[l];
      st_run[(int'(col[l])+16)*SLEN +: SLEN] = y2[l];
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: if (in_valid_i) begin
        st_d  = state_i;
        cnt_d = '0;
        fsm_d = RUN;
      end
      RUN: begin
        st_d = st_run;
        if (cnt_q == LAST) fsm_d = DONE;
        else               cnt_d = cnt_q + 3'(LANES);
      end
      DONE: if (out_ready_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign in_ready_o  = (fsm_q == IDLE);
  assign out_valid_o = (fsm_q == DONE);
  assign state_o     = st_q;
endmodule

// File: tb/tb_bash_s_array.sv
// Bench for bash_s_array: four instances with LANES = 1, 2, 4, 8 (index i
// has LANES = 1<<i), driven one at a time by scenario tasks.
module tb_bash_s_array;
  typedef logic [24*64-1:0] st_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid  [4];
  logic out_ready [4];
  st_t  st_in     [4];
  logic in_ready  [4];
  logic out_valid [4];
  st_t  st_out    [4];

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bash_s_array #(.SLEN(64), .LANES(1 << g)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .state_i     (st_in[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .state_o     (st_out[g])
    );
  end

  // Reference model: bit-by-bit rotation of the byte-swapped word.
  int M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  int N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  int M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  int N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};

  function automatic logic [63:0] bsw(input logic [63:0] x);
    logic [63:0] y;
    for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
    return y;
  endfunction

  function automatic logic [63:0] brot(input logic [63:0] x, input int r);
    logic [63:0] y, z;
    y = bsw(x);
    for (int i = 0; i < 64; i++) z[(i + r) % 64] = y[i];
    return bsw(z);
  endfunction

  function automatic st_t model(input st_t s);
    st_t r;
    logic [63:0] a, b, c, x0, t, x1, x2;
    r = s;
    for (int j = 0; j < 8; j++) begin
      a  = s[j*64 +: 64];
      b  = s[(j+8)*64 +: 64];
      c  = s[(j+16)*64 +: 64];
      x0 = a ^ b ^ c;
      t  = b ^ brot(x0, N1[j]);
      x1 = brot(a, M1[j]) ^ t;
      x2 = c ^ brot(c, M2[j]) ^ brot(t, N2[j]);
      r[j*64 +: 64]      = x0 ^ (~x2 | x1);
      r[(j+8)*64 +: 64]  = x1 ^ (x0 | x2);
      r[(j+16)*64 +: 64] = x2 ^ (x0 & x1);
    end
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int k = 0; k < 48; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  function automatic int first_diff(input st_t a, input st_t b);
    for (int k = 0; k < 24; k++) if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present s to instance idx (assumed idle), wait for the result, release it.
  // lat counts the accepting edge as cycle 1.
  task automatic run_one(input int idx, input st_t s, output int lat, output st_t res);
    in_valid[idx] = 1'b1;
    st_in[idx]    = s;
    tick();
    in_valid[idx] = 1'b0;
    lat = 1;
    while (!out_valid[idx] && lat < 40) begin
      tick();
      lat++;
    end
    res = st_out[idx];
    if (!out_valid[idx]) begin
      errs++; checks++;
      $display("FAIL run_one_timeout idx=%0d out_valid=%b after %0d cycles", idx, out_valid[idx], lat);
    end
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1) begin errs++; $display("FAIL reset_in_ready idx=%0d got=%b exp=1", i, in_ready[i]); end
      checks++;
      if (out_valid[i] !== 1'b0) begin errs++; $display("FAIL reset_out_valid idx=%0d got=%b exp=0", i, out_valid[i]); end
      checks++;
      if (st_out[i] !== '0) begin errs++; $display("FAIL reset_state idx=%0d word%0d got=%h exp=0", i, first_diff(st_out[i], '0), st_out[i][first_diff(st_out[i], '0)*64 +: 64]); end
    end
    // Reset wins over a handshake on the same edge.
    in_valid[1] = 1'b1;
    st_in[1]    = '1;
    rst         = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    rst         = 1'b0;
    checks++;
    if (in_ready[1] !== 1'b1) begin errs++; $display("FAIL reset_priority_ready got=%b exp=1", in_ready[1]); end
    checks++;
    if (st_out[1] !== '0) begin errs++; $display("FAIL reset_priority_state word%0d got=%h exp=0", first_diff(st_out[1], '0), st_out[1][first_diff(st_out[1], '0)*64 +: 64]); end
  endtask

  task automatic test_zero();
    st_t res, exp;
    int lat, k;
    exp = '0;
    for (int w = 0; w < 8; w++) exp[w*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_one(1, '0, lat, res);
    checks++;
    if (lat !== 5) begin errs++; $display("FAIL zero_latency got=%0d exp=5", lat); end
    checks++;
    if (res !== exp) begin
      errs++; k = first_diff(res, exp);
      $display("FAIL zero_result word%0d got=%h exp=%h", k, res[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  // All-ones columns are rotation invariant: only the third word ends up ones.
  task automatic test_ones();
    st_t res, exp;
    int lat, k;
    exp = '0;
    for (int w = 16; w < 24; w++) exp[w*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      run_one(i, '1, lat, res);
      checks++;
      if (lat !== 8 / (1 << i) + 1) begin errs++; $display("FAIL ones_latency idx=%0d got=%0d exp=%0d", i, lat, 8 / (1 << i) + 1); end
      checks++;
      if (res !== exp) begin
        errs++; k = first_diff(res, exp);
        $display("FAIL ones_result idx=%0d word%0d got=%h exp=%h", i, k, res[k*64 +: 64], exp[k*64 +: 64]);
      end
    end
  endtask

  task automatic test_random();
    st_t s, res, exp;
    int lat, k;
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++) begin
        s   = rand_state();
        exp = model(s);
        run_one(i, s, lat, res);
        checks++;
        if (lat !== 8 / (1 << i) + 1) begin errs++; $display("FAIL rand_latency idx=%0d got=%0d exp=%0d", i, lat, 8 / (1 << i) + 1); end
        checks++;
        if (res !== exp) begin
          errs++; k = first_diff(res, exp);
          $display("FAIL rand_result idx=%0d word%0d got=%h exp=%h", i, k, res[k*64 +: 64], exp[k*64 +: 64]);
        end
      end
    end
  endtask

  task automatic test_stall();
    st_t s, v, exp;
    int n, k;
    s   = rand_state();
    exp = model(s);
    in_valid[1] = 1'b1;
    st_in[1]    = s;
    tick();
    in_valid[1] = 1'b0;
    n = 0;
    while (!out_valid[1] && n < 40) begin tick(); n++; end
    v = st_out[1];
    checks++;
    if (v !== exp) begin
      errs++; k = first_diff(v, exp);
      $display("FAIL stall_result word%0d got=%h exp=%h", k, v[k*64 +: 64], exp[k*64 +: 64]);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid[1] !== 1'b1) begin errs++; $display("FAIL stall_valid cycle=%0d got=%b exp=1", c, out_valid[1]); end
      checks++;
      if (st_out[1] !== exp) begin
        errs++; k = first_diff(st_out[1], exp);
        $display("FAIL stall_hold cycle=%0d word%0d got=%h exp=%h", c, k, st_out[1][k*64 +: 64], exp[k*64 +: 64]);
      end
    end
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    checks++;
    if (in_ready[1] !== 1'b1) begin errs++; $display("FAIL stall_release_ready got=%b exp=1", in_ready[1]); end
    checks++;
    if (out_valid[1] !== 1'b0) begin errs++; $display("FAIL stall_release_valid got=%b exp=0", out_valid[1]); end
  endtask

  // LANES = 4: accept, two RUN edges, then DONE. A different state is held
  // valid through RUN and DONE and must never be taken.
  task automatic test_run_ignore();
    st_t sa, sb, exp;
    int k;
    sa  = rand_state();
    sb  = rand_state();
    exp = model(sa);
    in_valid[2] = 1'b1;
    st_in[2]    = sa;
    tick();
    st_in[2]    = sb;
    tick();
    tick();
    tick();
    in_valid[2] = 1'b0;
    checks++;
    if (out_valid[2] !== 1'b1) begin errs++; $display("FAIL ignore_valid got=%b exp=1", out_valid[2]); end
    checks++;
    if (st_out[2] !== exp) begin
      errs++; k = first_diff(st_out[2], exp);
      $display("FAIL ignore_result word%0d got=%h exp=%h", k, st_out[2][k*64 +: 64], exp[k*64 +: 64]);
    end
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
        errs++; $display("FAIL ignore_not_captured cycle=%0d ready=%b valid=%b exp ready=1 valid=0", c, in_ready[2], out_valid[2]);
      end
    end
  endtask

  task automatic test_reset_run();
    st_t s, res, exp;
    int lat, k;
    in_valid[0] = 1'b1;
    st_in[0]    = rand_state();
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1) begin errs++; $display("FAIL rstrun_ready got=%b exp=1", in_ready[0]); end
    checks++;
    if (out_valid[0] !== 1'b0) begin errs++; $display("FAIL rstrun_valid got=%b exp=0", out_valid[0]); end
    checks++;
    if (st_out[0] !== '0) begin
      errs++; k = first_diff(st_out[0], '0);
      $display("FAIL rstrun_state word%0d got=%h exp=0", k, st_out[0][k*64 +: 64]);
    end
    s   = rand_state();
    exp = model(s);
    run_one(0, s, lat, res);
    checks++;
    if (lat !== 9) begin errs++; $display("FAIL rstrun_after_latency got=%0d exp=9", lat); end
    checks++;
    if (res !== exp) begin
      errs++; k = first_diff(res, exp);
      $display("FAIL rstrun_after_result word%0d got=%h exp=%h", k, res[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  task automatic test_back_to_back();
    st_t s, exp;
    int acc [3];
    int n, k, gap;
    for (int i = 0; i < 4; i++) begin
      s   = rand_state();
      exp = model(s);
      gap = 8 / (1 << i) + 2;
      in_valid[i]  = 1'b1;
      st_in[i]     = s;
      out_ready[i] = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
        if (in_ready[i]) begin acc[n] = cyc; n++; end
        if (out_valid[i]) begin
          checks++;
          if (st_out[i] !== exp) begin
            errs++; k = first_diff(st_out[i], exp);
            $display("FAIL b2b_result idx=%0d word%0d got=%h exp=%h", i, k, st_out[i][k*64 +: 64], exp[k*64 +: 64]);
          end
        end
        tick();
      end
      in_valid[i] = 1'b0;
      for (int c = 0; c < 40 && !in_ready[i]; c++) tick();
      out_ready[i] = 1'b0;
      checks++;
      if (n !== 3) begin
        errs++; $display("FAIL b2b_accepts idx=%0d got=%0d exp=3", i, n);
      end else begin
        checks++;
        if (acc[1] - acc[0] !== gap) begin errs++; $display("FAIL b2b_gap1 idx=%0d got=%0d exp=%0d", i, acc[1] - acc[0], gap); end
        checks++;
        if (acc[2] - acc[1] !== gap) begin errs++; $display("FAIL b2b_gap2 idx=%0d got=%0d exp=%0d", i, acc[2] - acc[1], gap); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      st_in[i]     = '0;
    end
    test_reset();
    test_zero();
    test_ones();
    test_random();
    test_stall();
    test_run_ignore();
    test_reset_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bash_s_array.md
BASH_S_ARRAY -- requirements
Module: bash_s_array

Interface
REQ-001 Parameter SLEN, default from bash_hash_params_pkg (64): word width in bits.
REQ-002 Parameter LANES, default 2: bash-S instances evaluated per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 in_valid_i  input  1  state_i holds a valid 24-word state.
REQ-006 in_ready_o  output  1  block accepts a new state.
REQ-007 state_i  input  24*SLEN  input state; word k at bits [k*SLEN +: SLEN], k = 0..23.
REQ-008 out_valid_o  output  1  state_o holds a completed result.
REQ-009 out_ready_i  input  1  downstream accepts state_o.
REQ-010 state_o  output  24*SLEN  result state, same word layout as state_i.

Function
REQ-011 Column j (j = 0..7) shall be the triple (w0, w1, w2) = (word j, word j+8, word j+16).
REQ-012 Each column shall be transformed by bash-S with rotation set (m1, n1, m2, n2) by column index.
- j0: 8,53,14,1. j1: 56,51,34,7. j2: 8,37,46,49. j3: 56,3,2,23.
- j4: 8,21,14,33. j5: 56,19,34,39. j6: 8,5,46,17. j7: 56,35,2,55.
REQ-013 bash-S shall compute the following; x<<<r is a left rotation of the byte-reversed (little-endian) word, reversed back after rotating.
- W0 = w0^w1^w2; T1 = w1^(W0<<<n1); W1 = (w0<<<m1)^T1; W2 = w2^(w2<<<m2)^(T1<<<n2).
- outputs: W0^(~W2|W1), W1^(W0|W2), W2^(W0&W1).
REQ-014 The rotation set shall be selected per lane by the column index being processed, not fixed per lane.
REQ-015 FSM states IDLE, RUN, DONE; in_ready_o = 1 only in IDLE; out_valid_o = 1 only in DONE.
REQ-016 IDLE: on in_valid_i = 1, capture state_i into the internal 24-word register, clear the column counter to 0, go to RUN.
REQ-017 RUN, each cycle: transform columns counter .. counter+LANES-1 in place and increment the counter by LANES.
REQ-018 RUN: after the cycle that processes column 7, go to DONE.
REQ-019 RUN shall last exactly 8/LANES cycles, so 8/LANES+1 cycles elapse from the accepting edge to out_valid_o = 1.
REQ-020 The column counter shall be 3 bits wide and reach 0 again only through a new capture, never by wrapping in RUN.
REQ-021 DONE: state_o and out_valid_o shall stay stable while out_ready_i = 0.
REQ-022 DONE: on out_ready_i = 1, go to IDLE; a new input is accepted no earlier than the following cycle, so there is one bubble cycle.
REQ-023 in_valid_i and state_i shall be ignored in RUN and DONE; there is no overlap and no queuing.
REQ-024 state_o shall be driven directly from the internal register at all times; its value is meaningful only while out_valid_o = 1.
REQ-025 LANES = 8 shall give a single RUN cycle with eight concurrent bash-S instances.

Reset
REQ-026 With rst_i = 1 at a clock edge: FSM shall go to IDLE, column counter to 0, internal state register to all zeros.
REQ-027 Reset values of outputs: in_ready_o = 1, out_valid_o = 0, state_o = 0.
REQ-028 Reset shall take priority over every transition, including a handshake on the same edge.
REQ-029 Reset in RUN or DONE shall discard the in-progress state.

Verification
REQ-030 All-zero state_i, LANES = 2: out_valid_o after 5 cycles; words 0..7 = 0xFFFFFFFFFFFFFFFF; words 8..23 = 0.
REQ-031 Random states for LANES = 1, 2, 4, 8: state_o matches a bit-exact model of REQ-011..014; latency is 9/5/3/2 cycles respectively.
REQ-032 out_ready_i held 0 for 10 cycles in DONE: state_o and out_valid_o stay constant; on release, in_ready_o = 1 on the next cycle.
REQ-033 in_valid_i pulsed with a different state during RUN: the result is unchanged and the pulse is not captured.
REQ-034 rst_i asserted in the second RUN cycle with LANES = 1: next cycle in_ready_o = 1, out_valid_o = 0, state_o = 0; a following input completes normally.
REQ-035 Back-to-back inputs with out_ready_i tied to 1: accepts are spaced exactly 8/LANES+2 cycles apart.
